// File: rtl/store_pkg.sv
// Shared definitions for the S2MM store path: FSM encoding, DataMover command
// and status field positions, and error-flag indices.
package store_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        STS  = 2'd3
    } state_t;

    localparam int CMD_W         = 72;
    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_DSA_LSB   = 24;
    localparam int CMD_DSA_W     = 6;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_DRR_BIT   = 31;
    localparam int CMD_ADDR_LSB  = 32;
    localparam int CMD_TAG_LSB   = 64;

    localparam int STS_ERR_LSB   = 4;
    localparam int STS_ERR_MSB   = 6;
    localparam int STS_OKAY_BIT  = 7;

    localparam int ERR_DM        = 0;
    localparam int ERR_TRIG      = 1;
    localparam int ERR_OVF       = 2;

    // INCR burst, end-of-frame and re-realign set; DSA and tag stay zero.
    function automatic logic [CMD_W-1:0] build_cmd(input logic [31:0] addr, input logic [11:0] btt);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: CMD_BTT_W] = {11'd0, btt};
        c[CMD_TYPE_BIT]             = 1'b1;
        c[CMD_DSA_LSB +: CMD_DSA_W] = '0;
        c[CMD_EOF_BIT]              = 1'b1;
        c[CMD_DRR_BIT]              = 1'b1;
        c[CMD_ADDR_LSB +: 32]       = addr;
        c[CMD_TAG_LSB +: 8]         = 8'd0;
        return c;
    endfunction

endpackage

// File: rtl/store_push_s_if.sv
// DataMover S2MM bundle: command channel, write data stream and status channel.
// The master side is the store engine, the slave side is the DataMover.
interface store_push_s_if
    import store_pkg::*;
#(
    parameter int HP_WD_BYTE = 4
);
    logic                    s_axis_s2mm_cmd_tvalid;
    logic                    s_axis_s2mm_cmd_tready;
    logic [CMD_W-1:0]        s_axis_s2mm_cmd_tdata;

    logic [HP_WD_BYTE*8-1:0] s_axis_s2mm_tdata;
    logic [HP_WD_BYTE-1:0]   s_axis_s2mm_tkeep;
    logic                    s_axis_s2mm_tlast;
    logic                    s_axis_s2mm_tvalid;
    logic                    s_axis_s2mm_tready;

    logic                    m_axis_s2mm_sts_tvalid;
    logic                    m_axis_s2mm_sts_tready;
    logic [7:0]              m_axis_s2mm_sts_tdata;
    logic                    m_axis_s2mm_sts_tkeep;
    logic                    m_axis_s2mm_sts_tlast;

    modport master (
        output s_axis_s2mm_cmd_tvalid, s_axis_s2mm_cmd_tdata,
        output s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tlast, s_axis_s2mm_tvalid,
        output m_axis_s2mm_sts_tready,
        input  s_axis_s2mm_cmd_tready, s_axis_s2mm_tready,
        input  m_axis_s2mm_sts_tvalid, m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast
    );

    modport slave (
        input  s_axis_s2mm_cmd_tvalid, s_axis_s2mm_cmd_tdata,
        input  s_axis_s2mm_tdata, s_axis_s2mm_tkeep, s_axis_s2mm_tlast, s_axis_s2mm_tvalid,
        input  m_axis_s2mm_sts_tready,
        output s_axis_s2mm_cmd_tready, s_axis_s2mm_tready,
        output m_axis_s2mm_sts_tvalid, m_axis_s2mm_sts_tdata, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tlast
    );

endinterface

// File: rtl/store_fifo_s.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on rd_data.
module store_fifo_s #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_rd;
    logic             do_wr;

    // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/store_push_s.sv
// Line store engine: buffers producer beats and writes each line to DDR through a
// Xilinx DataMover S2MM (command, data stream, status), with one queued trigger.
module store_push_s
    import store_pkg::*;
#(
    parameter int HP_WD_BYTE = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    store_push_s_if.master          axis,
    input  logic [29:0]             ddr_addr_i,
    input  logic [11:0]             line_size_i,
    input  logic                    start_i,
    input  logic                    triger_i,
    input  logic [9:0]              bank_id_i,
    input  logic [31:0]             addr_image_base_i,
    input  logic [31:0]             addr_result_base_i,
    input  logic [HP_WD_BYTE*8-1:0] store_data_i,
    input  logic                    store_data_en_i,
    output logic                    store_ready_o,
    output logic                    line_done_o,
    output logic                    busy_o,
    output logic [2:0]              err_o
);
    localparam int DW = HP_WD_BYTE * 8;

    state_t           state;
    logic             pending;
    logic [31:0]      line_addr;
    logic [11:0]      line_size_r;
    logic [12:0]      beat_cnt;
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_data;
    logic             line_done;
    logic [2:0]       err;

    logic [31:0]           base;
    logic [31:0]           addr_next;
    logic [31:0]           launch_addr;
    logic                  req;
    logic [12:0]           beats_total;
    logic [12:0]           rem;
    logic                  last_beat;
    logic [HP_WD_BYTE-1:0] keep_last;
    logic                  tvalid_int;
    logic                  pop;
    logic                  push;
    logic                  sts_bad;
    logic [DW-1:0]         fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                  unused_sig;

    assign base        = (bank_id_i[9:8] == 2'b00) ? addr_image_base_i : addr_result_base_i;
    assign req         = start_i || triger_i;
    assign addr_next   = start_i ? ({2'b00, ddr_addr_i} + base) : (line_addr + {20'd0, line_size_i});
    // A queued line already holds its address; a new request only computes the following one.
    assign launch_addr = pending ? line_addr : addr_next;

    assign beats_total = (13'(line_size_r) + 13'(HP_WD_BYTE - 1)) / 13'(HP_WD_BYTE);
    assign rem         = 13'(line_size_r) % 13'(HP_WD_BYTE);
    assign last_beat   = (beat_cnt == beats_total - 13'd1);

    always_comb begin
        keep_last = '0;
        for (int i = 0; i < HP_WD_BYTE; i++) begin
            keep_last[i] = (rem == 13'd0) || (13'(i) < rem);
        end
    end

    assign tvalid_int = (state == DATA) && !fifo_empty;
    assign pop        = tvalid_int && axis.s_axis_s2mm_tready;
    assign push       = store_data_en_i && !fifo_full;
    assign sts_bad    = (axis.m_axis_s2mm_sts_tdata[STS_ERR_MSB:STS_ERR_LSB] != 3'd0)
                     || !axis.m_axis_s2mm_sts_tdata[STS_OKAY_BIT];

    store_fifo_s #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (store_data_i),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stream outputs are forced to zero when idle so stale FIFO memory never leaks out.
    assign axis.s_axis_s2mm_tvalid     = tvalid_int;
    assign axis.s_axis_s2mm_tdata      = tvalid_int ? fifo_dout : '0;
    assign axis.s_axis_s2mm_tkeep      = tvalid_int ? (last_beat ? keep_last : '1) : '0;
    assign axis.s_axis_s2mm_tlast      = tvalid_int && last_beat;
    assign axis.s_axis_s2mm_cmd_tvalid = cmd_valid;
    assign axis.s_axis_s2mm_cmd_tdata  = cmd_data;
    assign axis.m_axis_s2mm_sts_tready = 1'b1;

    assign store_ready_o = !fifo_full;
    assign line_done_o   = line_done;
    assign busy_o        = (state != IDLE) || pending;
    assign err_o         = err;

    assign unused_sig = ^{bank_id_i[7:0], axis.m_axis_s2mm_sts_tdata[3:0],
                          axis.m_axis_s2mm_sts_tkeep, axis.m_axis_s2mm_sts_tlast, fifo_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            line_addr   <= '0;
            line_size_r <= '0;
            beat_cnt    <= '0;
            cmd_valid   <= 1'b0;
            cmd_data    <= '0;
            line_done   <= 1'b0;
            err         <= '0;
        end else begin
            line_done <= 1'b0;
            if (store_data_en_i && fifo_full) err[ERR_OVF] <= 1'b1;
            case (state)
                IDLE: begin
                    if (pending || req) begin
                        if (req) line_addr <= addr_next;
                        pending <= pending && req;
                        if (line_size_i == 12'd0) begin
                            line_done <= 1'b1;
                        end else begin
                            state       <= CMD;
                            cmd_valid   <= 1'b1;
                            cmd_data    <= build_cmd(launch_addr, line_size_i);
                            line_size_r <= line_size_i;
                        end
                    end
                end
                CMD: begin
                    if (axis.s_axis_s2mm_cmd_tready) begin
                        cmd_valid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        if (last_beat) state <= STS;
                        else           beat_cnt <= beat_cnt + 13'd1;
                    end
                end
                STS: begin
                    if (axis.m_axis_s2mm_sts_tvalid) begin
                        line_done <= 1'b1;
                        state     <= IDLE;
                        if (sts_bad) err[ERR_DM] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Requests during a line queue one follow-up; anything beyond that is lost.
            if (state != IDLE && req) begin
                if (pending) begin
                    err[ERR_TRIG] <= 1'b1;
                end else begin
                    pending   <= 1'b1;
                    line_addr <= addr_next;
                end
            end
        end
    end

endmodule
